// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU constants and helpers for the register write scoreboard.
// The scoreboard tracks outstanding writes per architectural register.
package reg_scoreboard_pkg;

    localparam int NUM_REGS    = 16;
    localparam int ADDR_W      = 4;
    localparam int CNT_W       = 2;
    localparam int CNT_MAX     = 3;
    localparam int STALL_CNT_W = 16;

    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [CNT_W-1:0]       cnt_t;
    typedef logic [NUM_REGS-1:0]    reg_vec_t;
    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

    // One-hot select of the register addressed by a pipeline event, or none.
    function automatic reg_vec_t decode_evt(input logic valid, input addr_t addr);
        reg_vec_t vec;
        vec = '0;
        if (valid) vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/scb_entry.sv
// State for one architectural register: outstanding-write count and load-pending flag.
// Issue, flush and retire fold into one signed delta so coincident events sum.
module scb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec_flush,
    input  logic dec_retire,
    input  logic ld_val,
    input  logic ld_clr,
    output cnt_t cnt,
    output logic ld,
    output logic err
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(CNT_MAX);

    logic signed [SUM_W-1:0] sum;
    logic                    underflow;
    logic                    overflow;
    cnt_t                    cnt_next;
    logic                    ld_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum = $signed({2'b00, cnt})
            + $signed({{(SUM_W-1){1'b0}}, inc})
            - $signed({{(SUM_W-1){1'b0}}, dec_flush})
            - $signed({{(SUM_W-1){1'b0}}, dec_retire});
        underflow = sum[SUM_W-1];
        overflow  = !underflow && (sum > SUM_MAX);
        err       = underflow || overflow;

        cnt_next = sum[CNT_W-1:0];
        if (underflow)     cnt_next = '0;
        else if (overflow) cnt_next = cnt_t'(CNT_MAX);

        // A new write's load flag wins over a same-cycle load return.
        ld_next = ld;
        if (inc)         ld_next = ld_val;
        else if (ld_clr) ld_next = 1'b0;
        if (cnt_next == '0) ld_next = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so all entries see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ld  <= ld_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: 16 scb_entry instances plus load-use/overflow stall
// selection, a sticky error flag and a saturating stall performance counter.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic        UseRA1D,
    input  logic        UseRA2D,
    input  logic        IssueD,
    input  logic        RegWriteD,
    input  logic [3:0]  WA3D,
    input  logic        MemtoRegD,
    input  logic        FlushE,
    input  logic        RegWriteE,
    input  logic [3:0]  WA3E,
    input  logic        LdDoneM,
    input  logic [3:0]  WA3M,
    input  logic        RetireW,
    input  logic [3:0]  WA3W,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE_o,
    output logic        ScbErr,
    output logic [15:0] StallCnt
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
    reg_vec_t ld_q;
    reg_vec_t err_evt;
    reg_vec_t inc_vec;
    reg_vec_t flush_vec;
    reg_vec_t retire_vec;
    reg_vec_t lddone_vec;
    logic     issue_write;
    logic     stall;

    assign issue_write = IssueD && RegWriteD;

    // Only loads stall a reader; ALU results are forwarded. A full counter blocks issue.
    always_comb begin
        stall = 1'b0;
        if (UseRA1D && cnt_q[RA1D] != '0 && ld_q[RA1D]) stall = 1'b1;
        if (UseRA2D && cnt_q[RA2D] != '0 && ld_q[RA2D]) stall = 1'b1;
        if (issue_write && cnt_q[WA3D] == cnt_t'(CNT_MAX)) stall = 1'b1;
    end

    assign StallD   = stall;
    assign StallF   = stall;
    assign FlushE_o = stall;

    assign inc_vec    = decode_evt(issue_write && !stall, WA3D);
    assign flush_vec  = decode_evt(FlushE && RegWriteE, WA3E);
    assign retire_vec = decode_evt(RetireW, WA3W);
    assign lddone_vec = decode_evt(LdDoneM, WA3M);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        scb_entry u_entry (
            .clk        (clk),
            .reset      (reset),
            .inc        (inc_vec[r]),
            .dec_flush  (flush_vec[r]),
            .dec_retire (retire_vec[r]),
            .ld_val     (MemtoRegD),
            .ld_clr     (lddone_vec[r]),
            .cnt        (cnt_q[r]),
            .ld         (ld_q[r]),
            .err        (err_evt[r])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ScbErr   <= 1'b0;
            StallCnt <= '0;
        end else begin
            if (|err_evt) ScbErr <= 1'b1;
            if (stall && StallCnt != '1) StallCnt <= StallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic compared against an arithmetic per-register reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  RA1D, RA2D, WA3D, WA3E, WA3M, WA3W;
    logic        UseRA1D, UseRA2D, IssueD, RegWriteD, MemtoRegD;
    logic        FlushE, RegWriteE, LdDoneM, RetireW;
    logic        StallF, StallD, FlushE_o, ScbErr;
    logic [15:0] StallCnt;

    int checks = 0;
    int errors = 0;

    int m_cnt [16];
    bit m_ld  [16];
    bit m_err;
    int m_scnt;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .RA1D      (RA1D),
        .RA2D      (RA2D),
        .UseRA1D   (UseRA1D),
        .UseRA2D   (UseRA2D),
        .IssueD    (IssueD),
        .RegWriteD (RegWriteD),
        .WA3D      (WA3D),
        .MemtoRegD (MemtoRegD),
        .FlushE    (FlushE),
        .RegWriteE (RegWriteE),
        .WA3E      (WA3E),
        .LdDoneM   (LdDoneM),
        .WA3M      (WA3M),
        .RetireW   (RetireW),
        .WA3W      (WA3W),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE_o  (FlushE_o),
        .ScbErr    (ScbErr),
        .StallCnt  (StallCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0;
        RA1D = '0; RA2D = '0; UseRA1D = 1'b0; UseRA2D = 1'b0;
        IssueD = 1'b0; RegWriteD = 1'b0; WA3D = '0; MemtoRegD = 1'b0;
        FlushE = 1'b0; RegWriteE = 1'b0; WA3E = '0;
        LdDoneM = 1'b0; WA3M = '0; RetireW = 1'b0; WA3W = '0;
    endtask

    function automatic bit model_stall();
        bit s;
        s = 1'b0;
        if (UseRA1D && m_cnt[RA1D] != 0 && m_ld[RA1D]) s = 1'b1;
        if (UseRA2D && m_cnt[RA2D] != 0 && m_ld[RA2D]) s = 1'b1;
        if (IssueD && RegWriteD && m_cnt[WA3D] == 3) s = 1'b1;
        return s;
    endfunction

    task automatic model_update(input bit stall);
        bit issued;
        int n;
        if (reset) begin
            foreach (m_cnt[r]) begin m_cnt[r] = 0; m_ld[r] = 1'b0; end
            m_err = 1'b0;
            m_scnt = 0;
            return;
        end
        issued = IssueD && RegWriteD && !stall;
        for (int r = 0; r < 16; r++) begin
            n = m_cnt[r];
            if (issued && WA3D == 4'(r)) n++;
            if (FlushE && RegWriteE && WA3E == 4'(r)) n--;
            if (RetireW && WA3W == 4'(r)) n--;
            if (n < 0) begin n = 0; m_err = 1'b1; end
            if (n > 3) begin n = 3; m_err = 1'b1; end
            if (issued && WA3D == 4'(r)) m_ld[r] = MemtoRegD;
            else if (LdDoneM && WA3M == 4'(r)) m_ld[r] = 1'b0;
            if (n == 0) m_ld[r] = 1'b0;
            m_cnt[r] = n;
        end
        if (stall && m_scnt < 65535) m_scnt++;
    endtask

    // Inputs are set at the falling edge; outputs are checked before and after the rising edge.
    task automatic step(input bit chk);
        bit exp_stall;
        #1;
        exp_stall = model_stall();
        if (chk) begin
            check("StallD", 32'(StallD), 32'(exp_stall));
            check("StallF", 32'(StallF), 32'(exp_stall));
            check("FlushE_o", 32'(FlushE_o), 32'(exp_stall));
        end
        @(posedge clk);
        model_update(exp_stall);
        @(negedge clk);
        if (chk) begin
            check("ScbErr", 32'(ScbErr), 32'(m_err));
            check("StallCnt", 32'(StallCnt), 32'(m_scnt));
            for (int r = 0; r < 16; r++) begin
                check($sformatf("cnt[%0d]", r), 32'(dut.cnt_q[r]), 32'(m_cnt[r]));
                check($sformatf("ld[%0d]", r), 32'(dut.ld_q[r]), 32'(m_ld[r]));
            end
        end
    endtask

    function automatic logic [3:0] pick_live(input bit want_load);
        int r;
        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(0, 15);
            if (m_cnt[r] > 0 && (!want_load || m_ld[r])) return 4'(r);
        end
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        foreach (m_cnt[r]) begin m_cnt[r] = 0; m_ld[r] = 1'b0; end
        m_err = 1'b0;
        m_scnt = 0;

        // Reset; the retire to an empty register inside reset must not raise ScbErr.
        idle();
        reset = 1'b1;
        step(1'b0);
        RetireW = 1'b1; WA3W = 4'd7;
        step(1'b1);
        idle();
        #1;
        check("reset_StallD", 32'(StallD), 32'd0);
        check("reset_ScbErr", 32'(ScbErr), 32'd0);
        check("reset_StallCnt", 32'(StallCnt), 32'd0);
        step(1'b1);

        // Load R2 then a dependent read stalls until the load data returns.
        IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd2; MemtoRegD = 1'b1;
        step(1'b1);
        idle();
        UseRA1D = 1'b1; RA1D = 4'd2; IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd6;
        #1;
        check("ldu_StallD", 32'(StallD), 32'd1);
        check("ldu_StallF", 32'(StallF), 32'd1);
        check("ldu_FlushE_o", 32'(FlushE_o), 32'd1);
        repeat (3) step(1'b1);
        LdDoneM = 1'b1; WA3M = 4'd2;
        step(1'b1);
        LdDoneM = 1'b0;
        #1;
        check("ldu_release", 32'(StallD), 32'd0);
        check("ldu_StallCnt", 32'(StallCnt), 32'd4);
        step(1'b1);
        idle();
        RetireW = 1'b1; WA3W = 4'd2;
        step(1'b1);
        WA3W = 4'd6;
        step(1'b1);

        // ALU write to R3 is forwarded: no stall, count held until retire.
        idle();
        IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd3;
        step(1'b1);
        idle();
        UseRA2D = 1'b1; RA2D = 4'd3;
        step(1'b1);
        check("alu_cnt3", 32'(dut.cnt_q[3]), 32'd1);
        idle();
        RetireW = 1'b1; WA3W = 4'd3;
        step(1'b1);
        check("alu_cnt3_retired", 32'(dut.cnt_q[3]), 32'd0);

        // Three writes to R5 fill its counter; the fourth is held off without error.
        idle();
        IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd5;
        repeat (3) step(1'b1);
        check("full_cnt5", 32'(dut.cnt_q[5]), 32'd3);
        #1;
        check("full_StallD", 32'(StallD), 32'd1);
        step(1'b1);
        check("full_ScbErr", 32'(ScbErr), 32'd0);
        check("full_cnt5_held", 32'(dut.cnt_q[5]), 32'd3);
        idle();
        RetireW = 1'b1; WA3W = 4'd5;
        repeat (3) step(1'b1);

        // Coincident issue and retire on R4 leave the count unchanged.
        idle();
        IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd4;
        step(1'b1);
        MemtoRegD = 1'b1; RetireW = 1'b1; WA3W = 4'd4;
        step(1'b1);
        check("coinc_cnt4", 32'(dut.cnt_q[4]), 32'd1);
        check("coinc_ld4", 32'(dut.ld_q[4]), 32'd1);
        idle();
        RetireW = 1'b1; WA3W = 4'd4;
        step(1'b1);

        // Randomized traffic, biased so decrements mostly hit live registers.
        for (int i = 0; i < 2000; i++) begin
            idle();
            reset     = ($urandom_range(0, 299) == 0);
            IssueD    = ($urandom_range(0, 1) == 1);
            RegWriteD = ($urandom_range(0, 4) != 0);
            WA3D      = 4'($urandom_range(0, 15));
            MemtoRegD = ($urandom_range(0, 4) < 2);
            UseRA1D   = ($urandom_range(0, 1) == 1);
            RA1D      = ($urandom_range(0, 1) == 1) ? pick_live(1'b1) : 4'($urandom_range(0, 15));
            UseRA2D   = ($urandom_range(0, 1) == 1);
            RA2D      = 4'($urandom_range(0, 15));
            FlushE    = ($urandom_range(0, 6) == 0);
            RegWriteE = ($urandom_range(0, 4) != 0);
            WA3E      = pick_live(1'b0);
            RetireW   = ($urandom_range(0, 2) == 0);
            WA3W      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : pick_live(1'b0);
            LdDoneM   = ($urandom_range(0, 3) == 0);
            WA3M      = pick_live(1'b1);
            step(1'b1);
        end

        // Underflow on an empty register is sticky until reset.
        idle();
        reset = 1'b1;
        step(1'b1);
        idle();
        RetireW = 1'b1; WA3W = 4'd7;
        step(1'b1);
        check("uf_ScbErr", 32'(ScbErr), 32'd1);
        check("uf_cnt7", 32'(dut.cnt_q[7]), 32'd0);
        idle();
        repeat (3) step(1'b1);
        check("uf_sticky", 32'(ScbErr), 32'd1);
        reset = 1'b1;
        step(1'b1);
        check("uf_reset_ScbErr", 32'(ScbErr), 32'd0);
        check("uf_reset_StallCnt", 32'(StallCnt), 32'd0);

        // A long load-use stall saturates the performance counter.
        idle();
        IssueD = 1'b1; RegWriteD = 1'b1; WA3D = 4'd2; MemtoRegD = 1'b1;
        step(1'b1);
        idle();
        UseRA1D = 1'b1; RA1D = 4'd2;
        for (int i = 0; i < 70000; i++) step(1'b0);
        step(1'b1);
        check("sat_StallCnt", 32'(StallCnt), 32'h0000FFFF);
        check("sat_StallD", 32'(StallD), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
